// File: rtl/reg_file_pkg.sv
// Shared widths, the 8x16 reset image and width helpers for the register file
// with scoreboard.
package reg_file_pkg;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_NREGS  = 8;

   // Entry 0 holds R0.
   localparam logic [7:0][15:0] RST_IMG = {16'd66, 16'd64, 16'd0, 16'd0,
                                           16'd69, 16'd4,  16'd14, 16'd1};

   function automatic int addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_w(input int n);
      return addr_w(n) + 1;
   endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: issue sets a bit, write-back clears it, and issue wins
// on a same-address collision. Also keeps a registered popcount.
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter  int NREGS  = DEF_NREGS,
   localparam int ADDR_W = addr_w(NREGS),
   localparam int CNT_W  = cnt_w(NREGS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic              i_iss_valid,
   input  logic [ADDR_W-1:0] i_iss_addr,
   output logic [NREGS-1:0]  o_busy,
   output logic [CNT_W-1:0]  o_busy_cnt
);
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic [CNT_W-1:0] r_cnt;

   always_comb begin
      w_busy_nxt = r_busy;
      if (i_we)        w_busy_nxt[i_wr_addr]  = 1'b0;
      if (i_iss_valid) w_busy_nxt[i_iss_addr] = 1'b1;
   end

   // Count is taken from the next-state vector so it tracks the bits exactly.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= CNT_W'($countones(w_busy_nxt));
      end
   end

   assign o_busy     = r_busy;
   assign o_busy_cnt = r_cnt;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports and an issue scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data/busy to reads.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int NREGS  = DEF_NREGS,
   localparam int ADDR_W = addr_w(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic [ADDR_W:0]   busy_cnt
);
   localparam bit USE_IMG = (DATA_W == 16) && (NREGS == 8);

   logic [NREGS-1:0][DATA_W-1:0] r_regs;
   logic [NREGS-1:0]             w_busy;

   function automatic logic [DATA_W-1:0] rst_val(input int i);
      logic [2:0] idx;
      idx = i[2:0];
      if (USE_IMG) return DATA_W'(RST_IMG[idx]);
      return '0;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= rst_val(i);
      end else if (we) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   reg_file_scoreboard #(.NREGS(NREGS)) u_sb (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_we       (we),
      .i_wr_addr  (wr_addr),
      .i_iss_valid(iss_valid),
      .i_iss_addr (iss_addr),
      .o_busy     (w_busy),
      .o_busy_cnt (busy_cnt)
   );

`ifdef REG_FILE_BYPASS_EN
   logic w_hit1, w_hit2, w_iss_wr;
   assign w_hit1   = we && (rd_addr1 == wr_addr);
   assign w_hit2   = we && (rd_addr2 == wr_addr);
   // A forwarded register stays busy only if a new producer claims it now.
   assign w_iss_wr = iss_valid && (iss_addr == wr_addr);
   assign rd_data1 = w_hit1 ? wr_data  : r_regs[rd_addr1];
   assign rd_data2 = w_hit2 ? wr_data  : r_regs[rd_addr2];
   assign rd_busy1 = w_hit1 ? w_iss_wr : w_busy[rd_addr1];
   assign rd_busy2 = w_hit2 ? w_iss_wr : w_busy[rd_addr2];
`else
   assign rd_data1 = r_regs[rd_addr1];
   assign rd_data2 = r_regs[rd_addr2];
   assign rd_busy1 = w_busy[rd_addr1];
   assign rd_busy2 = w_busy[rd_addr2];
`endif
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed table, hand sequences, a 32x16 instance and
// randomized traffic against an array-based reference model.
module tb_reg_file_sb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 16x8 instance
   logic        rst_n, we, iss_valid;
   logic [2:0]  wr_addr, rd_addr1, rd_addr2, iss_addr;
   logic [15:0] wr_data, rd_data1, rd_data2;
   logic        rd_busy1, rd_busy2;
   logic [3:0]  busy_cnt;

   reg_file_sb dut (
      .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .rd_busy1(rd_busy1), .rd_busy2(rd_busy2), .iss_valid(iss_valid), .iss_addr(iss_addr),
      .busy_cnt(busy_cnt));

   // 32x16 instance
   logic        b_rst_n, b_we, b_iss;
   logic [3:0]  b_wa, b_ra1, b_ra2, b_ia;
   logic [31:0] b_wd, b_rd1, b_rd2;
   logic        b_bz1, b_bz2;
   logic [4:0]  b_cnt;

   reg_file_sb #(.DATA_W(32), .NREGS(16)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .we(b_we), .wr_addr(b_wa), .wr_data(b_wd),
      .rd_addr1(b_ra1), .rd_addr2(b_ra2), .rd_data1(b_rd1), .rd_data2(b_rd2),
      .rd_busy1(b_bz1), .rd_busy2(b_bz2), .iss_valid(b_iss), .iss_addr(b_ia),
      .busy_cnt(b_cnt));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: plain arrays updated by the architectural rules.
   int m_mem[8];
   bit m_busy[8];
   int img[8] = '{1, 14, 4, 69, 0, 0, 64, 66};
   bit bypass;

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < 8; i++) c += m_busy[i];
      return c;
   endfunction

   function automatic int m_rd(input int ra);
      if (bypass && we && ra == int'(wr_addr)) return int'(wr_data);
      return m_mem[ra];
   endfunction

   function automatic bit m_bz(input int ra);
      if (bypass && we && ra == int'(wr_addr)) return iss_valid && (iss_addr == wr_addr);
      return m_busy[ra];
   endfunction

   task automatic m_edge();
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin m_mem[i] = img[i]; m_busy[i] = 0; end
      end else begin
         if (we) begin m_mem[wr_addr] = int'(wr_data); m_busy[wr_addr] = 0; end
         if (iss_valid) m_busy[iss_addr] = 1;
      end
   endtask

   typedef struct {
      bit rst; bit w; int wa; int wd; bit iss; int ia; int ra1; int ra2;
      int e_d1; int e_d2; bit e_b1; int e_cnt;
   } vec_t;
   vec_t tbl[12];

   initial begin
`ifdef REG_FILE_BYPASS_EN
      bypass = 1;
`else
      bypass = 0;
`endif
      rst_n = 0; we = 0; iss_valid = 0; wr_addr = 0; wr_data = 0;
      rd_addr1 = 0; rd_addr2 = 0; iss_addr = 0;
      b_rst_n = 0; b_we = 0; b_iss = 0; b_wa = 0; b_wd = 0; b_ra1 = 0; b_ra2 = 0; b_ia = 0;

      //           rst w  wa wd       iss ia ra1 ra2  d1       d2       b1 cnt
      tbl[0]  = '{1, 0, 0, 0,       0, 0, 3, 7,  69,      66,      0, 0};
      tbl[1]  = '{0, 1, 5, 'hBEEF,  0, 0, 5, 0,  'hBEEF,  1,       0, 0};
      tbl[2]  = '{0, 0, 0, 0,       1, 2, 2, 1,  4,       14,      1, 1};
      tbl[3]  = '{0, 0, 0, 0,       1, 4, 2, 4,  4,       0,       1, 2};
      tbl[4]  = '{0, 0, 0, 0,       1, 2, 4, 2,  0,       4,       1, 2};
      tbl[5]  = '{0, 1, 2, 'h1234,  0, 0, 2, 6,  'h1234,  64,      0, 1};
      tbl[6]  = '{0, 0, 0, 0,       1, 6, 6, 5,  64,      'hBEEF,  1, 2};
      tbl[7]  = '{0, 1, 6, 'hAAAA,  1, 6, 6, 3,  'hAAAA,  69,      1, 2};
      tbl[8]  = '{0, 1, 7, 'h5555,  1, 7, 7, 2,  'h5555,  'h1234,  1, 3};
      tbl[9]  = '{0, 1, 3, 0,       0, 0, 3, 7,  0,       'h5555,  0, 3};
      tbl[10] = '{1, 1, 1, 'h00FF,  1, 0, 1, 5,  14,      0,       0, 0};
      tbl[11] = '{0, 0, 0, 0,       0, 0, 0, 6,  1,       64,      0, 0};

      // Checked after the edge so forwarding does not change the expectation.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rst_n = !tbl[i].rst; we = tbl[i].w; wr_addr = 3'(tbl[i].wa); wr_data = 16'(tbl[i].wd);
         iss_valid = tbl[i].iss; iss_addr = 3'(tbl[i].ia);
         rd_addr1 = 3'(tbl[i].ra1); rd_addr2 = 3'(tbl[i].ra2);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_rd1", i), rd_data1, tbl[i].e_d1);
         chk($sformatf("tbl%0d_rd2", i), rd_data2, tbl[i].e_d2);
         chk($sformatf("tbl%0d_bz1", i), rd_busy1, tbl[i].e_b1);
         chk($sformatf("tbl%0d_cnt", i), busy_cnt, tbl[i].e_cnt);
      end

      // Same-cycle read of a register being written.
      @(negedge clk);
      rst_n = 1; we = 1; wr_addr = 5; wr_data = 16'hCAFE; iss_valid = 0; rd_addr1 = 5;
      #1 chk("samecyc_rd1", rd_data1, bypass ? 32'hCAFE : 32'h0);
      chk("samecyc_bz1", rd_busy1, 0);
      @(posedge clk); #1;
      chk("nextcyc_rd1", rd_data1, 32'hCAFE);
      @(negedge clk); we = 0;

      // Same-cycle collision seen through the read port.
      iss_valid = 1; iss_addr = 3; we = 1; wr_addr = 3; wr_data = 16'h0077; rd_addr2 = 3;
      #1 chk("coll_samecyc_rd2", rd_data2, bypass ? 32'h77 : 32'd69);
      chk("coll_samecyc_bz2", rd_busy2, 0 | bypass);
      @(posedge clk); #1;
      chk("coll_bz2", rd_busy2, 1);
      chk("coll_cnt", busy_cnt, 1);
      @(negedge clk); we = 0; iss_valid = 0;

      // 32x16: zero reset, then fill the whole scoreboard.
      @(negedge clk); b_rst_n = 0;
      @(negedge clk); b_rst_n = 1;
      for (int i = 0; i < 16; i++) begin
         b_ra1 = 4'(i); b_ra2 = 4'(15 - i); #1;
         chk($sformatf("b_rst_rd1_%0d", i), b_rd1, 0);
         chk($sformatf("b_rst_bz2_%0d", i), b_bz2, 0);
      end
      chk("b_rst_cnt", b_cnt, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); b_iss = 1; b_ia = 4'(i);
      end
      @(negedge clk); b_iss = 1; b_ia = 4'd9;
      @(negedge clk); b_iss = 0;
      #1 chk("b_full_cnt", b_cnt, 16);
      for (int i = 0; i < 16; i++) begin
         b_ra1 = 4'(i); #1;
         chk($sformatf("b_full_bz1_%0d", i), b_bz1, 1);
      end
      @(negedge clk); b_we = 1; b_wa = 4'd11; b_wd = 32'hDEAD_BEEF;
      @(negedge clk); b_we = 0; b_ra1 = 4'd11; #1;
      chk("b_wr_rd1", b_rd1, 32'hDEAD_BEEF);
      chk("b_wr_cnt", b_cnt, 15);

      // Random traffic on the 16x8 instance; first cycle resets to sync the model.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rst_n     = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
         we        = 1'($urandom_range(0, 1));
         wr_addr   = 3'($urandom_range(0, 7));
         wr_data   = 16'($urandom);
         iss_valid = 1'($urandom_range(0, 1));
         iss_addr  = 3'($urandom_range(0, 7));
         rd_addr1  = 3'($urandom_range(0, 7));
         rd_addr2  = (c % 3 == 0) ? wr_addr : 3'($urandom_range(0, 7));
         #1;
         if (c > 0) begin
            chk("rnd_rd1", rd_data1, m_rd(rd_addr1));
            chk("rnd_rd2", rd_data2, m_rd(rd_addr2));
            chk("rnd_bz1", rd_busy1, m_bz(rd_addr1));
            chk("rnd_bz2", rd_busy2, m_bz(rd_addr2));
            chk("rnd_cnt", busy_cnt, m_cnt());
         end
         @(posedge clk);
         m_edge();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
